// File: rtl/membus_master_if.sv
// membus_master_if: PDP-6 memory bus signals between one initiator port and a core memory.
// Initiator to memory: rq_cyc, rd_rq, wr_rq, sel[4] (addr bits 18..21), ma[15] (addr bits 21..35),
//   fmc_select, mb_out[36], wr_rs.  Memory to initiator: addr_ack, rd_rs, mb_in[36].
// Bit 0 of the PDP-6 word maps to index 35 here (MSB-first numbering folded onto [N-1:0]).
interface membus_master_if;
  logic        rq_cyc;
  logic        rd_rq;
  logic        wr_rq;
  logic [3:0]  sel;
  logic [14:0] ma;
  logic        fmc_select;
  logic [35:0] mb_out;
  logic        wr_rs;
  logic        addr_ack;
  logic        rd_rs;
  logic [35:0] mb_in;

  modport master (
    output rq_cyc, rd_rq, wr_rq, sel, ma, fmc_select, mb_out, wr_rs,
    input  addr_ack, rd_rs, mb_in
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, sel, ma, fmc_select, mb_out, wr_rs,
    output addr_ack, rd_rs, mb_in
  );
endinterface

// File: rtl/membus_master.sv
// membus_master: turns a local read / write / read-modify-write request into a PDP-6 memory bus
// cycle (rq_cyc -> addr_ack -> rd_rs -> data on MB -> wr_rs) and flags NXM on timeout.
// Ports: clk, reset (sync, active-high); req_i/rd_i/wr_i/fmc_i/addr_i[18]/wdata_i[36]/wdata_strb_i
//   from the client; busy_o, rdata_o[36], rd_done_o, done_o, nxm_o back to it; bus = membus master side.
// addr_i[17] is PDP-6 address bit 18, addr_i[0] is bit 35; sel and ma share address bit 21.
module membus_master #(
  parameter int TMO_CYC = 4000,  // cycles allowed in ADDR or RDWAIT before NXM
  parameter int SETTLE  = 5,     // cycles write data settles on MB before wr_rs
  parameter int RS_W    = 10     // cycles wr_rs is held high
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  input  logic            rd_i,
  input  logic            wr_i,
  input  logic            fmc_i,
  input  logic [17:0]     addr_i,
  input  logic [35:0]     wdata_i,
  input  logic            wdata_strb_i,
  output logic            busy_o,
  output logic [35:0]     rdata_o,
  output logic            rd_done_o,
  output logic            done_o,
  output logic            nxm_o,
  membus_master_if.master bus
);

  localparam int CNT_MAX = (TMO_CYC > SETTLE) ? ((TMO_CYC > RS_W) ? TMO_CYC : RS_W)
                                              : ((SETTLE > RS_W) ? SETTLE : RS_W);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] RS_LAST     = CNT_W'(RS_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_RMWAIT = 3'd3;
  localparam logic [2:0] S_WRDATA = 3'd4;
  localparam logic [2:0] S_WRRS   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;  // one cycle carrying the done pulse
  localparam logic [2:0] S_ABORT  = 3'd7;  // one cycle carrying the nxm pulse, bus released

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [17:0]      addr_q, addr_d;
  logic             fmc_q, fmc_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [35:0]      rdata_q, rdata_d;
  logic [35:0]      wdata_q, wdata_d;
  logic             rd_done_q, rd_done_d;
  logic             ack_prev_q, rs_prev_q;

  logic ack_rise, rs_rise;

  // Memory handshakes are multi-cycle pulses; only the rising edge is acted on.
  assign ack_rise = bus.addr_ack & ~ack_prev_q;
  assign rs_rise  = bus.rd_rs & ~rs_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    fmc_d     = fmc_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    rd_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i && (rd_i || wr_i)) begin
          addr_d  = addr_i;
          fmc_d   = fmc_i;
          rd_d    = rd_i;
          wr_d    = wr_i;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (ack_rise) begin
          cnt_d = '0;
          if (rd_q) begin
            state_d = S_RDWAIT;
          end else begin
            wdata_d = wdata_i;
            state_d = S_WRDATA;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RDWAIT: begin
        // MB is a wired-OR; accumulate like the PDP-6 MB register so partial strobes add up.
        rdata_d = rdata_q | bus.mb_in;
        if (rs_rise) begin
          rd_done_d = 1'b1;
          state_d   = wr_q ? S_RMWAIT : S_FIN;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RMWAIT: begin
        // The memory is parked waiting for wr_rs, so there is no timeout here.
        if (wdata_strb_i) begin
          wdata_d = wdata_i;
          cnt_d   = '0;
          state_d = S_WRDATA;
        end
      end

      S_WRDATA: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_WRRS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WRRS: begin
        if (cnt_q == RS_LAST) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FIN, S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      fmc_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      rd_done_q  <= 1'b0;
      ack_prev_q <= 1'b0;
      rs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      fmc_q      <= fmc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      rd_done_q  <= rd_done_d;
      ack_prev_q <= bus.addr_ack;
      rs_prev_q  <= bus.rd_rs;
    end
  end

  // Address/fmc are presented for the whole cycle but withdrawn in IDLE and on NXM abort.
  logic on_bus;
  assign on_bus = (state_q != S_IDLE) && (state_q != S_ABORT);

  assign bus.rq_cyc     = (state_q == S_ADDR);
  assign bus.rd_rq      = (state_q == S_ADDR) & rd_q;
  assign bus.wr_rq      = (state_q == S_ADDR) & wr_q;
  assign bus.sel        = on_bus ? addr_q[17:14] : 4'd0;
  assign bus.ma         = on_bus ? addr_q[14:0] : 15'd0;
  assign bus.fmc_select = on_bus & fmc_q;
  // MB is zero outside the write phases so the memory always sees a clean 0 -> data transition.
  assign bus.mb_out     = ((state_q == S_WRDATA) || (state_q == S_WRRS)) ? wdata_q : 36'd0;
  assign bus.wr_rs      = (state_q == S_WRRS);

  assign busy_o    = (state_q != S_IDLE);
  assign rdata_o   = rdata_q;
  assign rd_done_o = rd_done_q;
  assign done_o    = (state_q == S_FIN);
  assign nxm_o     = (state_q == S_ABORT);

endmodule

// File: tb/tb_membus_master.sv
// Bench for membus_master: a behavioural core memory on the slave modport, a monitor that scores
// rd_done data against an expected-value queue and tallies bus activity, and one task per scenario.
module tb_membus_master;
  localparam int TMO_CYC = 4000;
  localparam int SETTLE  = 5;
  localparam int RS_W    = 10;

  localparam int A_RD  = 'o000100;
  localparam int A_WR  = 'o000200;
  localparam int A_RMW = 'o000300;
  localparam int A_NXM = 'o000400;
  localparam int A_RST = 'o000500;
  localparam int A_ZW  = 'o000600;
  localparam int A_IGN = 'o000700;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, rd_i, wr_i, fmc_i, wdata_strb_i;
  logic [17:0] addr_i;
  logic [35:0] wdata_i;
  logic        busy_o, rd_done_o, done_o, nxm_o;
  logic [35:0] rdata_o;

  always #5 clk = ~clk;

  membus_master_if bus();

  membus_master #(.TMO_CYC(TMO_CYC), .SETTLE(SETTLE), .RS_W(RS_W)) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .rd_i(rd_i), .wr_i(wr_i), .fmc_i(fmc_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wdata_strb_i(wdata_strb_i),
    .busy_o(busy_o), .rdata_o(rdata_o), .rd_done_o(rd_done_o), .done_o(done_o), .nxm_o(nxm_o),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [35:0] mem [int];
  bit          mem_present = 1'b1;
  bit          model_busy = 1'b0;
  logic [35:0] exp_q [$];

  // monitor tallies
  int rd_done_cnt, done_cnt, nxm_cnt, wr_rs_cnt, mb_nz_cnt, rq_cnt, rq_rise_cnt, ack_rise_cnt;
  int rd_done_cyc, done_cyc, nxm_cyc, wr_rs_last_cyc, mb_first_cyc, ack_rise_cyc, rs_rise_cyc;
  int busy_fall_cyc;
  logic [33:0] nxm_bus;
  bit ack_prev = 0, rs_prev = 0, rq_prev = 0, busy_prev = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic clear_mon();
    rd_done_cnt = 0; done_cnt = 0; nxm_cnt = 0; wr_rs_cnt = 0; mb_nz_cnt = 0;
    rq_cnt = 0; rq_rise_cnt = 0; ack_rise_cnt = 0;
    rd_done_cyc = -1; done_cyc = -1; nxm_cyc = -1; wr_rs_last_cyc = -1; mb_first_cyc = -1;
    ack_rise_cyc = -1; rs_rise_cyc = -1; busy_fall_cyc = -1; nxm_bus = '0;
  endtask

  // Monitor + scoreboard, sampled mid-cycle.
  initial begin : monitor
    logic [35:0] e;
    clear_mon();
    forever begin
      @(negedge clk);
      if (bus.addr_ack && !ack_prev) begin ack_rise_cnt++; ack_rise_cyc = cyc; end
      if (bus.rd_rs && !rs_prev) rs_rise_cyc = cyc;
      if (bus.rq_cyc) rq_cnt++;
      if (bus.rq_cyc && !rq_prev) rq_rise_cnt++;
      if (bus.wr_rs) begin wr_rs_cnt++; wr_rs_last_cyc = cyc; end
      if (bus.mb_out != 36'd0) begin
        if (mb_nz_cnt == 0) mb_first_cyc = cyc;
        mb_nz_cnt++;
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (nxm_o) begin
        nxm_cnt++; nxm_cyc = cyc;
        nxm_bus = {bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.sel, bus.ma, bus.fmc_select,
                   bus.wr_rs, (bus.mb_out != 36'd0)};
      end
      if (!busy_o && busy_prev) busy_fall_cyc = cyc;
      if (rd_done_o) begin
        rd_done_cnt++; rd_done_cyc = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_rdata: unexpected rd_done, rdata=%o", rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (rdata_o !== e) begin
            tests_failed++;
            $display("FAIL sb_rdata: rdata=%o expected %o", rdata_o, e);
          end
        end
      end
      ack_prev = bus.addr_ack; rs_prev = bus.rd_rs; rq_prev = bus.rq_cyc; busy_prev = busy_o;
    end
  end

  // Core-memory model: destructive read with self-restore, clear-then-OR write on wr_rs.
  initial begin : mem_model
    int a;
    logic [35:0] word;
    bit rdreq, wrreq, seen;
    bus.addr_ack = 1'b0; bus.rd_rs = 1'b0; bus.mb_in = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_present && bus.rq_cyc) begin
        model_busy = 1'b1;
        a = int'({bus.sel, bus.ma[13:0]});
        rdreq = bus.rd_rq; wrreq = bus.wr_rq;
        repeat (2) @(posedge clk); #1;
        bus.addr_ack = 1'b1;
        word = mem.exists(a) ? mem[a] : 36'd0;
        mem[a] = 36'd0;
        repeat (3) @(posedge clk); #1;
        bus.addr_ack = 1'b0;
        if (rdreq) begin
          bus.mb_in = word;
          @(posedge clk); #1;
          bus.rd_rs = 1'b1;
          repeat (3) @(posedge clk); #1;
          bus.rd_rs = 1'b0; bus.mb_in = '0;
          if (!wrreq) mem[a] = word;
        end
        if (wrreq) begin
          seen = 1'b0;
          for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.wr_rs) begin seen = 1'b1; mem[a] = mem[a] | bus.mb_out; end
            else if (seen) break;
          end
        end
        model_busy = 1'b0;
      end
    end
  end

  task automatic issue(input bit r, input bit w, input bit f, input int a, input logic [35:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; rd_i = r; wr_i = w; fmc_i = f; addr_i = 18'(a); wdata_i = d;
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    expired = busy_o;
  endtask

  task automatic wait_model(output bit expired);
    int n;
    n = 0;
    @(negedge clk);
    while (model_busy && n < 500) begin @(negedge clk); n++; end
    expired = model_busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests_run++;
    if (rdata_o !== 36'd0) begin tests_failed++; $display("FAIL reset_rdata: got %o want 0", rdata_o); end
    tests_run++;
    if ({bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.wr_rs, bus.fmc_select} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctl: got %b want 00000",
                               {bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.wr_rs, bus.fmc_select});
    end
    tests_run++;
    if ({bus.sel, bus.ma} !== 19'd0 || bus.mb_out !== 36'd0) begin
      tests_failed++; $display("FAIL reset_addr_mb: sel=%o ma=%o mb=%o want 0", bus.sel, bus.ma, bus.mb_out);
    end
    tests_run++;
    if ({rd_done_o, done_o, nxm_o} !== 3'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got %b want 000", {rd_done_o, done_o, nxm_o});
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    bit exp_t;
    logic [35:0] v;
    v = 36'o123456654321;
    mem[A_RD] = v;
    clear_mon();
    exp_q.push_back(v);
    issue(1'b1, 1'b0, 1'b1, A_RD, 36'd0);
    tests_run++;
    if ({bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.fmc_select} !== 4'b1101) begin
      tests_failed++; $display("FAIL rd_req_lines: got %b want 1101",
                               {bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.fmc_select});
    end
    tests_run++;
    if (int'({bus.sel, bus.ma[13:0]}) != A_RD || bus.ma[14] !== bus.sel[0]) begin
      tests_failed++; $display("FAIL rd_addr: sel=%o ma=%o want addr %o", bus.sel, bus.ma, A_RD);
    end
    wait_idle(200, exp_t);
    tests_run++;
    if (exp_t) begin tests_failed++; $display("FAIL rd_timeout: busy=%b want 0", busy_o); end
    tests_run++;
    if (rd_done_cnt != 1 || done_cnt != 1 || nxm_cnt != 0 || wr_rs_cnt != 0) begin
      tests_failed++; $display("FAIL rd_counts: rd_done=%0d done=%0d nxm=%0d wr_rs=%0d want 1 1 0 0",
                               rd_done_cnt, done_cnt, nxm_cnt, wr_rs_cnt);
    end
    tests_run++;
    if (rd_done_cyc != rs_rise_cyc + 1 || done_cyc != rd_done_cyc) begin
      tests_failed++; $display("FAIL rd_latency: rs_rise=%0d rd_done=%0d done=%0d want rd_done=done=rs_rise+1",
                               rs_rise_cyc, rd_done_cyc, done_cyc);
    end
    tests_run++;
    if (busy_fall_cyc != done_cyc + 1) begin
      tests_failed++; $display("FAIL rd_busy_drop: busy fell at %0d want %0d", busy_fall_cyc, done_cyc + 1);
    end
    tests_run++;
    if (rdata_o !== v) begin tests_failed++; $display("FAIL rd_hold: rdata=%o want %o", rdata_o, v); end
    wait_model(exp_t);
    tests_run++;
    if (exp_t || mem[A_RD] !== v) begin
      tests_failed++; $display("FAIL rd_restore: mem=%o want %o", mem[A_RD], v);
    end
  endtask

  task automatic test_write();
    bit exp_t;
    logic [35:0] v;
    v = 36'o777777000000;
    mem[A_WR] = 36'o1234;
    clear_mon();
    issue(1'b0, 1'b1, 1'b0, A_WR, v);
    tests_run++;
    if ({bus.rq_cyc, bus.rd_rq, bus.wr_rq} !== 3'b101) begin
      tests_failed++; $display("FAIL wr_req_lines: got %b want 101", {bus.rq_cyc, bus.rd_rq, bus.wr_rq});
    end
    wait_idle(200, exp_t);
    tests_run++;
    if (exp_t) begin tests_failed++; $display("FAIL wr_timeout: busy=%b want 0", busy_o); end
    tests_run++;
    if (mb_nz_cnt != SETTLE + RS_W || mb_first_cyc != ack_rise_cyc + 1) begin
      tests_failed++; $display("FAIL wr_mb_window: nonzero %0d cycles from %0d, want %0d from %0d",
                               mb_nz_cnt, mb_first_cyc, SETTLE + RS_W, ack_rise_cyc + 1);
    end
    tests_run++;
    if (wr_rs_cnt != RS_W) begin
      tests_failed++; $display("FAIL wr_rs_width: got %0d want %0d", wr_rs_cnt, RS_W);
    end
    tests_run++;
    if (done_cnt != 1 || rd_done_cnt != 0 || done_cyc != wr_rs_last_cyc + 1) begin
      tests_failed++; $display("FAIL wr_done: done=%0d rd_done=%0d at %0d want 1 0 at %0d",
                               done_cnt, rd_done_cnt, done_cyc, wr_rs_last_cyc + 1);
    end
    wait_model(exp_t);
    tests_run++;
    if (exp_t || mem[A_WR] !== v) begin
      tests_failed++; $display("FAIL wr_mem: mem=%o want %o", mem[A_WR], v);
    end
  endtask

  task automatic test_rmw();
    bit exp_t;
    int n;
    mem[A_RMW] = 36'd5;
    clear_mon();
    exp_q.push_back(36'd5);
    issue(1'b1, 1'b1, 1'b0, A_RMW, 36'd0);
    tests_run++;
    if ({bus.rq_cyc, bus.rd_rq, bus.wr_rq} !== 3'b111) begin
      tests_failed++; $display("FAIL rmw_req_lines: got %b want 111", {bus.rq_cyc, bus.rd_rq, bus.wr_rq});
    end
    n = 0;
    while (rd_done_cnt == 0 && n < 200) begin @(negedge clk); n++; end
    tests_run++;
    if (rd_done_cnt == 0) begin tests_failed++; $display("FAIL rmw_rd_done: got 0 pulses want 1"); end
    repeat (3) @(posedge clk);
    tests_run++;
    if (busy_o !== 1'b1 || done_cnt != 0) begin
      tests_failed++; $display("FAIL rmw_park: busy=%b done=%0d want 1 0", busy_o, done_cnt);
    end
    @(posedge clk); #1;
    wdata_i = 36'd6; wdata_strb_i = 1'b1;
    @(posedge clk); #1;
    wdata_strb_i = 1'b0;
    wait_idle(200, exp_t);
    tests_run++;
    if (exp_t) begin tests_failed++; $display("FAIL rmw_timeout: busy=%b want 0", busy_o); end
    tests_run++;
    if (done_cnt != 1 || rd_done_cnt != 1 || wr_rs_cnt != RS_W || done_cyc != wr_rs_last_cyc + 1) begin
      tests_failed++; $display("FAIL rmw_seq: done=%0d rd_done=%0d wr_rs=%0d done@%0d want 1 1 %0d @%0d",
                               done_cnt, rd_done_cnt, wr_rs_cnt, done_cyc, RS_W, wr_rs_last_cyc + 1);
    end
    wait_model(exp_t);
    tests_run++;
    if (exp_t || mem[A_RMW] !== 36'd6) begin
      tests_failed++; $display("FAIL rmw_mem: mem=%o want 6", mem[A_RMW]);
    end
  endtask

  task automatic test_nxm();
    bit exp_t;
    mem_present = 1'b0;
    clear_mon();
    issue(1'b1, 1'b0, 1'b1, A_NXM, 36'd0);
    wait_idle(TMO_CYC + 100, exp_t);
    tests_run++;
    if (exp_t) begin tests_failed++; $display("FAIL nxm_timeout: busy=%b want 0", busy_o); end
    tests_run++;
    if (nxm_cnt != 1 || done_cnt != 0 || rd_done_cnt != 0) begin
      tests_failed++; $display("FAIL nxm_pulses: nxm=%0d done=%0d rd_done=%0d want 1 0 0",
                               nxm_cnt, done_cnt, rd_done_cnt);
    end
    tests_run++;
    if (rq_cnt != TMO_CYC || nxm_cyc != busy_fall_cyc - 1) begin
      tests_failed++; $display("FAIL nxm_timing: rq_cyc %0d cycles nxm@%0d busy_fall@%0d want %0d cycles",
                               rq_cnt, nxm_cyc, busy_fall_cyc, TMO_CYC);
    end
    tests_run++;
    if (nxm_bus !== 34'd0) begin
      tests_failed++; $display("FAIL nxm_bus_drop: bus during nxm=%b want 0", nxm_bus);
    end
    tests_run++;
    if ({bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.wr_rs, bus.fmc_select, busy_o} !== 6'b0 ||
        {bus.sel, bus.ma} !== 19'd0 || bus.mb_out !== 36'd0) begin
      tests_failed++; $display("FAIL nxm_idle: ctl=%b sel=%o ma=%o mb=%o want 0",
                               {bus.rq_cyc, bus.rd_rq, bus.wr_rq, bus.wr_rs, bus.fmc_select, busy_o},
                               bus.sel, bus.ma, bus.mb_out);
    end
    mem_present = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit exp_t;
    int n;
    mem[A_RST] = 36'o777;
    clear_mon();
    issue(1'b1, 1'b0, 1'b0, A_RST, 36'd0);
    n = 0;
    while (ack_rise_cnt == 0 && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (ack_rise_cnt == 0) begin tests_failed++; $display("FAIL rst_ack_wait: no addr_ack seen"); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || rdata_o !== 36'd0 || {bus.sel, bus.ma} !== 19'd0 ||
        {bus.rq_cyc, bus.rd_rq, bus.fmc_select} !== 3'b0) begin
      tests_failed++; $display("FAIL rst_mid_clear: busy=%b rdata=%o sel=%o ma=%o want all 0",
                               busy_o, rdata_o, bus.sel, bus.ma);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (done_cnt != 0 || nxm_cnt != 0 || rd_done_cnt != 0 || rdata_o !== 36'd0) begin
      tests_failed++; $display("FAIL rst_mid_quiet: done=%0d nxm=%0d rd_done=%0d rdata=%o want 0",
                               done_cnt, nxm_cnt, rd_done_cnt, rdata_o);
    end
    wait_model(exp_t);
    clear_mon();
    exp_q.push_back(36'o777);
    issue(1'b1, 1'b0, 1'b0, A_RST, 36'd0);
    wait_idle(200, exp_t);
    tests_run++;
    if (exp_t || done_cnt != 1 || rd_done_cnt != 1) begin
      tests_failed++; $display("FAIL rst_reread: done=%0d rd_done=%0d busy=%b want 1 1 0",
                               done_cnt, rd_done_cnt, busy_o);
    end
    wait_model(exp_t);
  endtask

  task automatic test_busy_req_zero_write();
    bit exp_t;
    mem[A_ZW] = 36'o55;
    clear_mon();
    issue(1'b0, 1'b1, 1'b0, A_ZW, 36'd0);
    repeat (3) @(posedge clk);
    #1;
    req_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; addr_i = 18'(A_IGN);
    @(posedge clk); #1;
    req_i = 1'b0;
    wait_idle(200, exp_t);
    tests_run++;
    if (exp_t) begin tests_failed++; $display("FAIL zw_timeout: busy=%b want 0", busy_o); end
    tests_run++;
    if (mb_nz_cnt != 0 || wr_rs_cnt != RS_W || done_cnt != 1) begin
      tests_failed++; $display("FAIL zw_bus: mb nonzero %0d wr_rs %0d done %0d want 0 %0d 1",
                               mb_nz_cnt, wr_rs_cnt, done_cnt, RS_W);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (rq_rise_cnt != 1 || busy_o !== 1'b0 || rd_done_cnt != 0) begin
      tests_failed++; $display("FAIL busy_req_ignored: rq_cyc rises %0d busy=%b rd_done=%0d want 1 0 0",
                               rq_rise_cnt, busy_o, rd_done_cnt);
    end
    wait_model(exp_t);
    tests_run++;
    if (exp_t || mem[A_ZW] !== 36'd0) begin
      tests_failed++; $display("FAIL zw_mem: mem=%o want 0", mem[A_ZW]);
    end
  endtask

  initial begin
    reset = 1'b1; req_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; fmc_i = 1'b0;
    addr_i = '0; wdata_i = '0; wdata_strb_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_rmw();
    test_nxm();
    test_reset_mid();
    test_busy_req_zero_write();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL sb_drain: %0d expected reads never returned, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
